// File: rtl/apb_rr_master_arbiter.sv
// Round-robin arbiter sharing one APB master port between NUM_REQ local requesters.
// Latency: request seen in IDLE at T -> psel T+1, penable T+2, rsp_done T+3 with zero wait states.
// Backpressure: requesters hold req_valid until rsp_done; a PREADY timeout forces an error completion.
module apb_rr_master_arbiter #(
    parameter int NUM_REQ        = 4,
    parameter int ADDR_WIDTH     = 32,
    parameter int DATA_WIDTH     = 32,
    parameter int TIMEOUT_CYCLES = 16
) (
    input  logic                             pclk,
    input  logic                             presetn,
    input  logic [NUM_REQ-1:0]               req_valid,
    input  logic [NUM_REQ-1:0]               req_write,
    input  logic [NUM_REQ*ADDR_WIDTH-1:0]    req_addr,
    input  logic [NUM_REQ*DATA_WIDTH-1:0]    req_wdata,
    output logic [NUM_REQ-1:0]               rsp_done,
    output logic [DATA_WIDTH-1:0]            rsp_rdata,
    output logic                             rsp_err,
    output logic                             psel,
    output logic                             penable,
    output logic                             pwrite,
    output logic [ADDR_WIDTH-1:0]            paddr,
    output logic [DATA_WIDTH-1:0]            pwdata,
    input  logic [DATA_WIDTH-1:0]            prdata,
    input  logic                             pready,
    input  logic                             pslverr
);

    localparam int GW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [GW-1:0] LAST_IDX  = GW'(NUM_REQ - 1);
    localparam logic [CW-1:0] TMO_LAST  = CW'(TIMEOUT_CYCLES - 1);

    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_SETUP  = 2'd1;
    localparam logic [1:0] ST_ACCESS = 2'd2;

    logic [1:0]            state_q, state_d;
    logic [GW-1:0]         last_grant_q, last_grant_d;
    logic [GW-1:0]         grant_q, grant_d;
    logic [CW-1:0]         cnt_q, cnt_d;
    logic                  psel_q, psel_d;
    logic                  penable_q, penable_d;
    logic                  pwrite_q, pwrite_d;
    logic [ADDR_WIDTH-1:0] paddr_q, paddr_d;
    logic [DATA_WIDTH-1:0] pwdata_q, pwdata_d;
    logic [NUM_REQ-1:0]    done_q, done_d;
    logic [DATA_WIDTH-1:0] rdata_q, rdata_d;
    logic                  err_q, err_d;

    logic [NUM_REQ-1:0]    eligible;
    logic                  arb_hit;
    logic [GW-1:0]         arb_idx;
    logic [GW-1:0]         cand;
    logic                  sel_write;
    logic [ADDR_WIDTH-1:0] sel_addr;
    logic [DATA_WIDTH-1:0] sel_wdata;

    // Round-robin pick: first eligible requester after last_grant, wrapping; a requester
    // whose done pulse is out this cycle is masked so it is not re-granted the same transfer.
    always_comb begin
        eligible = req_valid & ~done_q;
        arb_hit  = 1'b0;
        arb_idx  = last_grant_q;
        cand     = '0;
        for (int k = 1; k <= NUM_REQ; k++) begin
            cand = GW'((int'(last_grant_q) + k) % NUM_REQ);
            for (int i = 0; i < NUM_REQ; i++) begin
                if (!arb_hit && (cand == GW'(i)) && eligible[i]) begin
                    arb_hit = 1'b1;
                    arb_idx = cand;
                end
            end
        end
    end

    // Mux the winning requester's command fields.
    always_comb begin
        sel_write = 1'b0;
        sel_addr  = '0;
        sel_wdata = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (arb_idx == GW'(i)) begin
                sel_write = req_write[i];
                sel_addr  = req_addr[i*ADDR_WIDTH +: ADDR_WIDTH];
                sel_wdata = req_wdata[i*DATA_WIDTH +: DATA_WIDTH];
            end
        end
    end

    // Next-state logic: IDLE grants, SETUP lasts one cycle, ACCESS waits for pready or timeout.
    always_comb begin
        state_d      = state_q;
        last_grant_d = last_grant_q;
        grant_d      = grant_q;
        cnt_d        = cnt_q;
        psel_d       = psel_q;
        penable_d    = penable_q;
        pwrite_d     = pwrite_q;
        paddr_d      = paddr_q;
        pwdata_d     = pwdata_q;
        done_d       = '0;
        rdata_d      = '0;
        err_d        = 1'b0;
        case (state_q)
            ST_IDLE: begin
                psel_d    = 1'b0;
                penable_d = 1'b0;
                cnt_d     = '0;
                if (arb_hit) begin
                    grant_d      = arb_idx;
                    last_grant_d = arb_idx;
                    pwrite_d     = sel_write;
                    paddr_d      = sel_addr;
                    pwdata_d     = sel_wdata;
                    psel_d       = 1'b1;
                    state_d      = ST_SETUP;
                end
            end
            ST_SETUP: begin
                penable_d = 1'b1;
                state_d   = ST_ACCESS;
            end
            ST_ACCESS: begin
                if (pready || (cnt_q == TMO_LAST)) begin
                    psel_d    = 1'b0;
                    penable_d = 1'b0;
                    cnt_d     = '0;
                    state_d   = ST_IDLE;
                    for (int i = 0; i < NUM_REQ; i++) begin
                        done_d[i] = (grant_q == GW'(i));
                    end
                    if (pready) begin
                        rdata_d = pwrite_q ? '0 : prdata;
                        err_d   = pslverr;
                    end else begin
                        rdata_d = '0;
                        err_d   = 1'b1;
                    end
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            default: begin
                psel_d    = 1'b0;
                penable_d = 1'b0;
                cnt_d     = '0;
                state_d   = ST_IDLE;
            end
        endcase
    end

    // State and output registers; reset drops the bus immediately and restores requester 0 priority.
    always_ff @(posedge pclk or negedge presetn) begin
        if (!presetn) begin
            state_q      <= ST_IDLE;
            last_grant_q <= LAST_IDX;
            grant_q      <= '0;
            cnt_q        <= '0;
            psel_q       <= 1'b0;
            penable_q    <= 1'b0;
            pwrite_q     <= 1'b0;
            paddr_q      <= '0;
            pwdata_q     <= '0;
            done_q       <= '0;
            rdata_q      <= '0;
            err_q        <= 1'b0;
        end else begin
            state_q      <= state_d;
            last_grant_q <= last_grant_d;
            grant_q      <= grant_d;
            cnt_q        <= cnt_d;
            psel_q       <= psel_d;
            penable_q    <= penable_d;
            pwrite_q     <= pwrite_d;
            paddr_q      <= paddr_d;
            pwdata_q     <= pwdata_d;
            done_q       <= done_d;
            rdata_q      <= rdata_d;
            err_q        <= err_d;
        end
    end

    assign psel      = psel_q;
    assign penable   = penable_q;
    assign pwrite    = pwrite_q;
    assign paddr     = paddr_q;
    assign pwdata    = pwdata_q;
    assign rsp_done  = done_q;
    assign rsp_rdata = rdata_q;
    assign rsp_err   = err_q;

endmodule

// File: tb/tb_apb_rr_master_arbiter.sv
// Directed bench for apb_rr_master_arbiter with a small APB slave responder.
// Latency: checks psel/penable/rsp_done cycle positions relative to request sampling.
// Backpressure: slave wait states and hang (timeout) are driven per vector.
module tb_apb_rr_master_arbiter;

    logic         pclk;
    logic         presetn;
    logic [3:0]   req_valid;
    logic [3:0]   req_write;
    logic [127:0] req_addr;
    logic [127:0] req_wdata;
    logic [3:0]   rsp_done;
    logic [31:0]  rsp_rdata;
    logic         rsp_err;
    logic         psel;
    logic         penable;
    logic         pwrite;
    logic [31:0]  paddr;
    logic [31:0]  pwdata;
    logic [31:0]  prdata;
    logic         pready;
    logic         pslverr;

    apb_rr_master_arbiter #(
        .NUM_REQ(4), .ADDR_WIDTH(32), .DATA_WIDTH(32), .TIMEOUT_CYCLES(16)
    ) dut (
        .pclk(pclk), .presetn(presetn),
        .req_valid(req_valid), .req_write(req_write),
        .req_addr(req_addr), .req_wdata(req_wdata),
        .rsp_done(rsp_done), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
        .psel(psel), .penable(penable), .pwrite(pwrite),
        .paddr(paddr), .pwdata(pwdata),
        .prdata(prdata), .pready(pready), .pslverr(pslverr)
    );

    initial pclk = 1'b0;
    always #5 pclk = ~pclk;

    int n_total = 0;
    int n_pass  = 0;

    // Slave responder state
    int          sl_waits = 0;
    logic        sl_hang  = 1'b0;
    logic        sl_err   = 1'b0;
    logic [31:0] sl_rdata = 32'h0;
    int          acc_cnt  = 0;

    typedef struct {
        int          req;
        logic        wr;
        logic [31:0] addr;
        logic [31:0] wdata;
        int          waits;
        logic        hang;
        logic        slverr;
        logic [31:0] rdata;
        logic [3:0]  exp_done;
        logic [31:0] exp_rdata;
        logic        exp_err;
        int          exp_lat;
    } vec_t;

    vec_t vt [7];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_total++;
        if (act !== exp) $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        else n_pass++;
    endtask

    // One clock; inputs change 1 time unit after the edge, slave reacts to the new bus state.
    task automatic tick();
        @(posedge pclk);
        #1;
        if (psel && penable) begin
            pready = (!sl_hang && (acc_cnt == sl_waits));
            acc_cnt++;
        end else begin
            acc_cnt = 0;
            pready  = 1'b0;
        end
        prdata  = sl_rdata;
        pslverr = sl_err;
    endtask

    task automatic set_req(input int i, input logic wr, input logic [31:0] a, input logic [31:0] d);
        req_write[i] = wr;
        req_addr[i*32 +: 32]  = a;
        req_wdata[i*32 +: 32] = d;
    endtask

    task automatic run_vec(input int n);
        vec_t v;
        int lat;
        logic seen, stable_ok;
        logic [3:0] got_done;
        logic [31:0] got_rdata;
        logic got_err;
        v = vt[n];
        sl_waits = v.waits; sl_hang = v.hang; sl_err = v.slverr; sl_rdata = v.rdata;
        set_req(v.req, v.wr, v.addr, v.wdata);
        req_valid = '0;
        req_valid[v.req] = 1'b1;
        seen = 1'b0; stable_ok = 1'b1; lat = 0;
        got_done = '0; got_rdata = '0; got_err = 1'b0;
        for (int c = 1; c <= 40 && !seen; c++) begin
            tick();
            if (c == 1) begin
                check($sformatf("v%0d_psel", n), {63'd0, psel}, 64'd1);
                check($sformatf("v%0d_paddr", n), {32'd0, paddr}, {32'd0, v.addr});
                check($sformatf("v%0d_pwrite", n), {63'd0, pwrite}, {63'd0, v.wr});
                check($sformatf("v%0d_pwdata", n), {32'd0, pwdata}, {32'd0, v.wdata});
            end
            if (c == 2) check($sformatf("v%0d_penable", n), {63'd0, penable}, 64'd1);
            if (psel && (paddr !== v.addr || pwrite !== v.wr || pwdata !== v.wdata)) stable_ok = 1'b0;
            if (rsp_done != 4'd0) begin
                seen = 1'b1; lat = c;
                got_done = rsp_done; got_rdata = rsp_rdata; got_err = rsp_err;
            end
        end
        check($sformatf("v%0d_done_seen", n), {63'd0, seen}, 64'd1);
        check($sformatf("v%0d_latency", n), 64'(lat), 64'(v.exp_lat));
        check($sformatf("v%0d_rsp_done", n), {60'd0, got_done}, {60'd0, v.exp_done});
        check($sformatf("v%0d_rsp_rdata", n), {32'd0, got_rdata}, {32'd0, v.exp_rdata});
        check($sformatf("v%0d_rsp_err", n), {63'd0, got_err}, {63'd0, v.exp_err});
        check($sformatf("v%0d_cmd_stable", n), {63'd0, stable_ok}, 64'd1);
        req_valid = '0;
        tick();
        check($sformatf("v%0d_done_pulse", n), {60'd0, rsp_done}, 64'd0);
        tick();
    endtask

    int order [6];
    int when  [6];
    int nd;
    int t_tmo;
    logic seen_x;
    logic gap_ok;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        //           req wr  addr          wdata         wt hang err rdata         done     exp_rdata     err lat
        vt[0] = '{1, 1'b1, 32'h10, 32'hA5A5_0001, 0, 1'b0, 1'b0, 32'h1111_1111, 4'b0010, 32'h0,         1'b0, 3};
        vt[1] = '{2, 1'b0, 32'h20, 32'h0000_0002, 3, 1'b0, 1'b0, 32'hDEAD_BEEF, 4'b0100, 32'hDEAD_BEEF, 1'b0, 6};
        vt[2] = '{0, 1'b0, 32'h30, 32'h0000_0003, 0, 1'b0, 1'b1, 32'h1234_5678, 4'b0001, 32'h1234_5678, 1'b1, 3};
        vt[3] = '{0, 1'b0, 32'h34, 32'h0000_0004, 1, 1'b0, 1'b0, 32'h0BAD_F00D, 4'b0001, 32'h0BAD_F00D, 1'b0, 4};
        vt[4] = '{3, 1'b1, 32'h40, 32'hCAFE_0005, 0, 1'b1, 1'b0, 32'h7777_7777, 4'b1000, 32'h0,         1'b1, 18};
        vt[5] = '{3, 1'b0, 32'h44, 32'h0000_0006, 0, 1'b1, 1'b0, 32'h8888_8888, 4'b1000, 32'h0,         1'b1, 18};
        vt[6] = '{1, 1'b1, 32'h50, 32'h0000_0007, 2, 1'b0, 1'b1, 32'hFFFF_FFFF, 4'b0010, 32'h0,         1'b1, 5};

        presetn = 1'b0;
        req_valid = '0; req_write = '0; req_addr = '0; req_wdata = '0;
        prdata = '0; pready = 1'b0; pslverr = 1'b0;

        // Reset state
        tick(); tick();
        check("rst_psel", {63'd0, psel}, 64'd0);
        check("rst_penable", {63'd0, penable}, 64'd0);
        check("rst_outputs", {pwrite, paddr, rsp_err, rsp_done, 27'd0}, 64'd0);
        check("rst_data", {pwdata, rsp_rdata}, 64'd0);

        // Fairness: all four valid continuously out of reset
        for (int i = 0; i < 4; i++) set_req(i, 1'b0, 32'h1000 + 32'(i) * 32'h10, 32'h0);
        req_valid = 4'b1111;
        sl_waits = 0; sl_hang = 1'b0; sl_err = 1'b0; sl_rdata = 32'h0;
        presetn = 1'b1;
        nd = 0;
        for (int c = 1; c <= 60 && nd < 6; c++) begin
            tick();
            if (rsp_done != 4'd0) begin
                order[nd] = (rsp_done == 4'b0001) ? 0 : (rsp_done == 4'b0010) ? 1 :
                            (rsp_done == 4'b0100) ? 2 : (rsp_done == 4'b1000) ? 3 : 9;
                when[nd] = c;
                nd++;
                if (nd == 6) req_valid = '0;
            end
        end
        check("fair_count", 64'(nd), 64'd6);
        check("fair_first_lat", 64'(when[0]), 64'd3);
        for (int k = 0; k < 6; k++) check($sformatf("fair_order%0d", k), 64'(order[k]), 64'(k % 4));
        gap_ok = 1'b1;
        for (int k = 1; k < 6; k++) if (when[k] - when[k-1] != 3) gap_ok = 1'b0;
        check("fair_spacing", {63'd0, gap_ok}, 64'd1);
        tick(); tick();

        // Table-driven single transfers
        for (int n = 0; n < 7; n++) run_vec(n);

        // Timeout on req 3 with req 0 pending, then req 0 served next
        sl_hang = 1'b1; sl_waits = 0; sl_err = 1'b0; sl_rdata = 32'h0;
        set_req(3, 1'b0, 32'h300, 32'h0);
        set_req(0, 1'b1, 32'h400, 32'h55);
        req_valid = 4'b1000;
        tick(); tick();
        req_valid = 4'b1001;
        seen_x = 1'b0; t_tmo = 0;
        for (int c = 3; c <= 40 && !seen_x; c++) begin
            tick();
            if (rsp_done != 4'd0) begin
                seen_x = 1'b1; t_tmo = c;
                check("tmo_done", {60'd0, rsp_done}, 64'b1000);
                check("tmo_err", {63'd0, rsp_err}, 64'd1);
            end
        end
        check("tmo_seen", {63'd0, seen_x}, 64'd1);
        check("tmo_lat", 64'(t_tmo), 64'd18);
        req_valid[3] = 1'b0;
        sl_hang = 1'b0;
        tick();
        check("tmo_next_psel", {63'd0, psel}, 64'd1);
        check("tmo_next_paddr", {32'd0, paddr}, 64'h400);
        seen_x = 1'b0;
        for (int c = 2; c <= 20 && !seen_x; c++) begin
            tick();
            if (rsp_done != 4'd0) begin
                seen_x = 1'b1;
                check("tmo_next_done", {60'd0, rsp_done}, 64'b0001);
                check("tmo_next_lat", 64'(c), 64'd3);
            end
        end
        check("tmo_next_seen", {63'd0, seen_x}, 64'd1);
        req_valid = '0;
        tick(); tick();

        // Reset during a req 1 wait state
        sl_hang = 1'b1;
        set_req(1, 1'b0, 32'h100, 32'h0);
        req_valid = 4'b0010;
        seen_x = 1'b0;
        for (int c = 1; c <= 10 && !seen_x; c++) begin
            tick();
            if (penable) seen_x = 1'b1;
        end
        check("rstmid_access", {63'd0, seen_x}, 64'd1);
        tick(); tick();
        #2 presetn = 1'b0;
        #1;
        check("rstmid_psel", {63'd0, psel}, 64'd0);
        check("rstmid_penable", {63'd0, penable}, 64'd0);
        seen_x = 1'b0;
        for (int c = 0; c < 2; c++) begin
            tick();
            if (rsp_done != 4'd0) seen_x = 1'b1;
        end
        check("rstmid_no_done", {63'd0, seen_x}, 64'd0);
        set_req(0, 1'b0, 32'h200, 32'h0);
        sl_hang = 1'b0; sl_waits = 0;
        req_valid = 4'b0011;
        presetn = 1'b1;
        tick();
        check("rstmid_grant_psel", {63'd0, psel}, 64'd1);
        check("rstmid_grant_paddr", {32'd0, paddr}, 64'h200);
        seen_x = 1'b0;
        for (int c = 2; c <= 20 && !seen_x; c++) begin
            tick();
            if (rsp_done != 4'd0) begin
                seen_x = 1'b1;
                check("rstmid_done0", {60'd0, rsp_done}, 64'b0001);
                req_valid[0] = 1'b0;
            end
        end
        check("rstmid_done0_seen", {63'd0, seen_x}, 64'd1);
        seen_x = 1'b0;
        for (int c = 1; c <= 20 && !seen_x; c++) begin
            tick();
            if (rsp_done != 4'd0) begin
                seen_x = 1'b1;
                check("rstmid_done1", {60'd0, rsp_done}, 64'b0010);
                check("rstmid_lat1", 64'(c), 64'd3);
            end
        end
        check("rstmid_done1_seen", {63'd0, seen_x}, 64'd1);
        req_valid = '0;
        tick(); tick();

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/apb_rr_master_arbiter.md
Name: apb_rr_master_arbiter

Overview:
- Shares one APB master port to the SRAM slave between NUM_REQ local requesters.
- Arbitration is round-robin.
- Each granted request is sequenced through the APB SETUP/ACCESS phases.
- Responses are returned per requester.
- A PREADY timeout guards against a hung slave.

Parameters:
- NUM_REQ, 4, number of requesters (1..8).
- ADDR_WIDTH, 32, APB address width.
- DATA_WIDTH, 32, APB data width.
- TIMEOUT_CYCLES, 16, maximum ACCESS cycles without pready before forced error completion (>=2).

Ports:
- pclk  in  1  clock.
- presetn  in  1  reset; asynchronous assert, active-low.
- req_valid  in  NUM_REQ  per-requester request, held until matching rsp_done.
- req_write  in  NUM_REQ  1=write, 0=read.
- req_addr  in  NUM_REQ*ADDR_WIDTH  packed addresses; requester i at [i*ADDR_WIDTH +: ADDR_WIDTH].
- req_wdata  in  NUM_REQ*DATA_WIDTH  packed write data.
- rsp_done  out  NUM_REQ  one-cycle completion pulse, one-hot.
- rsp_rdata  out  DATA_WIDTH  read data, valid while rsp_done high.
- rsp_err  out  1  error flag, valid while rsp_done high.
- psel  out  1  APB select.
- penable  out  1  APB enable.
- pwrite  out  1  APB direction.
- paddr  out  ADDR_WIDTH  APB address.
- pwdata  out  DATA_WIDTH  APB write data.
- prdata  in  DATA_WIDTH  APB read data.
- pready  in  1  APB ready.
- pslverr  in  1  APB slave error.

Behaviour:
- Reset (presetn=0, asynchronous):
  - state=IDLE.
  - psel, penable, pwrite, paddr, pwdata, rsp_done, rsp_rdata, rsp_err all 0.
  - last_grant=NUM_REQ-1, so requester 0 has top priority after reset.
  - Timeout counter = 0.
- All outputs are registered.
- FSM states IDLE, SETUP, ACCESS.
- IDLE:
  - Eligible = req_valid & ~rsp_done (a requester whose done pulse is this cycle is masked).
  - If any eligible, grant the first eligible index searching upward from last_grant+1 modulo NUM_REQ.
  - On grant: capture that requester's write/addr/wdata into pwrite/paddr/pwdata, set psel=1, set last_grant=grant, go to SETUP.
  - Otherwise stay in IDLE; psel=0.
- SETUP: exactly one cycle with psel=1, penable=0; then ACCESS with penable=1.
- ACCESS:
  - Timeout counter increments each cycle that pready=0.
  - pready=1 completes the transfer; next cycle:
    - psel=0, penable=0.
    - rsp_done[grant]=1.
    - rsp_rdata = prdata for reads, 0 for writes.
    - rsp_err = pslverr.
    - state=IDLE, counter cleared.
  - If the counter reaches TIMEOUT_CYCLES with pready=0: complete the same way with rsp_err=1, rsp_rdata=0.
- paddr/pwrite/pwdata are stable from SETUP through the last ACCESS cycle.
- Latency: req_valid sampled high in IDLE at cycle T gives:
  - psel at T+1.
  - penable at T+2.
  - With zero wait states, pready sampled at T+2 and rsp_done at T+3.
- Minimum spacing is one IDLE cycle between transfers; back-to-back throughput is one transfer per 3 cycles.
- Request fields change after grant: ignored.
- req_valid drops mid-transfer: the transfer still completes and rsp_done still pulses.
- Requester protocol: after rsp_done, deassert req_valid, or present a new request, the following cycle. A requester holding valid high is re-arbitrated one cycle later at lowest priority.
- NUM_REQ=1: same behaviour; the masking forces one extra idle cycle between consecutive requests.
- pslverr/prdata are ignored outside ACCESS with pready=1.
- Reset mid-ACCESS: bus drops immediately (psel=penable=0), no rsp_done is issued, and the pointer returns to NUM_REQ-1.

Test Plan:
- Single write, zero wait states: req 1 writes addr 0x10, data 0xA5A5_0001 at T → psel at T+1, penable T+2, rsp_done=4'b0010 at T+3, rsp_err=0.
- Read with 3 wait states: req 2 reads 0x20, slave returns 0xDEAD_BEEF with pready at the 4th ACCESS cycle → rsp_rdata=0xDEAD_BEEF, rsp_done[2] pulses one cycle after pready.
- Fairness: all 4 requesters valid continuously from reset → grant order 0,1,2,3,0,1; no requester granted twice within 4 transfers.
- Slave error: req 0 read with pslverr=1 and pready=1 → rsp_err=1 with rsp_done[0]; the next transfer completes with rsp_err=0.
- Timeout: pready held 0 for req 3 → rsp_done[3] after exactly 16 ACCESS cycles with rsp_err=1, rsp_rdata=0; the arbiter then serves the next pending requester.
- Reset mid-ACCESS: presetn low during a req 1 wait state → psel/penable 0 asynchronously, no rsp_done; after release with req 0 and req 1 valid, req 0 is granted first.
